// File: rtl/mem_copy_master.sv
// Word-copy DMA initiator: reads LEN words from SRC and writes them to DST over a
// single req/ready memory port, one read beat then one write beat per word.
//
// state   | meaning
// IDLE    | waiting for start
// RD_REQ  | read beat outstanding at src + 4*words_done
// RD_GAP  | one idle cycle after the read; abort is honoured here
// WR_REQ  | write beat outstanding at dst + 4*words_done
// WR_GAP  | one idle cycle after the write; finish or fetch the next word
// DONE    | job over; done/busy update on the following cycle
module mem_copy_master #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic              m_mem_req,
  output logic              m_mem_we,
  output logic [ADDR_W-1:0] m_mem_addr,
  output logic [XLEN-1:0]   m_mem_wdata,
  input  logic [XLEN-1:0]   m_mem_rdata,
  input  logic              m_mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_GAP, S_WR_REQ, S_WR_GAP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d, words_q, words_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic              abort_seen_q, abort_seen_d;
  logic              aborted_q, aborted_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] offset;
  logic              working;
  logic              abort_any;

  assign offset    = ADDR_W'(words_q) << 2;
  assign working   = (state_q == S_RD_REQ) || (state_q == S_RD_GAP) ||
                     (state_q == S_WR_REQ) || (state_q == S_WR_GAP);
  assign abort_any = abort_seen_q || (working && abort);

  // Port outputs decode straight from state so they stay frozen while a beat waits.
  assign m_mem_req   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign m_mem_we    = (state_q == S_WR_REQ);
  assign m_mem_addr  = (state_q == S_RD_REQ) ? src_q + offset :
                       (state_q == S_WR_REQ) ? dst_q + offset : '0;
  assign m_mem_wdata = (state_q == S_WR_REQ) ? buf_q : '0;

  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign words_done = words_q;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    words_d      = words_q;
    buf_d        = buf_q;
    abort_seen_d = abort_seen_q || (working && abort);
    aborted_d    = aborted_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        abort_seen_d = 1'b0;
        if (start) begin
          src_d     = {cfg_src[ADDR_W-1:2], 2'b00};
          dst_d     = {cfg_dst[ADDR_W-1:2], 2'b00};
          len_d     = cfg_len;
          words_d   = '0;
          aborted_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = (cfg_len == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (m_mem_ready) begin
          buf_d   = m_mem_rdata;
          state_d = S_RD_GAP;
        end
      end
      S_RD_GAP: begin
        if (abort_any) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (m_mem_ready) begin
          words_d = words_q + 1'b1;
          state_d = S_WR_GAP;
        end
      end
      S_WR_GAP: begin
        if (abort_any || (words_q == len_q)) begin
          aborted_d = abort_any;
          state_d   = S_DONE;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      words_q      <= '0;
      buf_q        <= '0;
      abort_seen_q <= 1'b0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      words_q      <= words_d;
      buf_q        <= buf_d;
      abort_seen_q <= abort_seen_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: random-latency memory responder with a word-array
// memory, directed jobs checked against the expected copy result.
module tb_mem_copy_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_src = '0;
  logic [31:0] cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic        busy, done, aborted;
  logic [15:0] words_done;
  logic        m_mem_req, m_mem_we;
  logic [31:0] m_mem_addr, m_mem_wdata;
  logic [31:0] m_mem_rdata = '0;
  logic        m_mem_ready = 1'b0;

  mem_copy_master #(.ADDR_W(32), .XLEN(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
    .m_mem_req(m_mem_req), .m_mem_we(m_mem_we), .m_mem_addr(m_mem_addr),
    .m_mem_wdata(m_mem_wdata), .m_mem_rdata(m_mem_rdata), .m_mem_ready(m_mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int min_wait = 1;
  int max_wait = 1;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] wlog [$];
  int req_cycles = 0, done_pulses = 0, busy_cycles = 0, stab_viol = 0, gap_viol = 0;

  // Memory responder: decides ready at each negedge, commits the beat seen at the posedge.
  initial begin
    logic        p_req, p_rdy, p_we, pend;
    logic [31:0] p_addr, p_wd;
    int          wl;
    p_req = 1'b0; p_rdy = 1'b0; p_we = 1'b0; pend = 1'b0;
    p_addr = '0; p_wd = '0; wl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0; p_req = 1'b0; p_rdy = 1'b0;
        m_mem_ready = 1'b0; m_mem_rdata = '0;
      end else begin
        if (p_req && p_rdy) begin
          if (p_we) begin
            mem[p_addr] = p_wd;
            wlog.push_back(p_addr);
          end
          if (m_mem_req !== 1'b0) gap_viol++;
        end else if (p_req) begin
          if (m_mem_req !== 1'b1 || m_mem_we !== p_we || m_mem_addr !== p_addr ||
              m_mem_wdata !== p_wd) stab_viol++;
        end
        if (m_mem_req === 1'b1) req_cycles++;
        if (done === 1'b1) done_pulses++;
        if (busy === 1'b1) busy_cycles++;
        if (m_mem_req === 1'b1) begin
          if (!pend) begin
            pend = 1'b1;
            wl = int'($urandom_range(max_wait, min_wait));
          end
          if (wl == 0) begin
            m_mem_ready = 1'b1;
            pend = 1'b0;
            if (!m_mem_we) m_mem_rdata = mem.exists(m_mem_addr) ? mem[m_mem_addr] : 32'h0;
            else m_mem_rdata = $urandom;
          end else begin
            m_mem_ready = 1'b0;
            m_mem_rdata = $urandom;
            wl--;
          end
        end else begin
          pend = 1'b0;
          m_mem_ready = ($urandom_range(1, 0) == 1);
          m_mem_rdata = $urandom;
        end
        p_req = m_mem_req; p_rdy = m_mem_ready; p_we = m_mem_we;
        p_addr = m_mem_addr; p_wd = m_mem_wdata;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    cfg_src = s; cfg_dst = d; cfg_len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of posedges from the one that sampled start to the done pulse.
  task automatic wait_done(input string tag, input int budget, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  int          cyc, s_done, s_req, s_busy, s_stab, s_gap, w0, n, guard;
  logic [31:0] rs, rd;
  logic [31:0] vals [32];

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    check("rst_words", 64'(words_done), 64'd0);
    check("rst_req", 64'({m_mem_req, m_mem_we}), 64'd0);
    check("rst_addr_wdata", {m_mem_addr, m_mem_wdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 4-word copy, ready exactly one cycle after req: 6 cycles per word.
    for (int i = 0; i < 4; i++) begin
      mem[32'h1000 + 32'(4*i)] = 32'hCAFE0000 + 32'(i);
      mem[32'h2000 + 32'(4*i)] = 32'h0;
    end
    mem[32'h2010] = 32'h5A5A5A5A;
    min_wait = 1; max_wait = 1;
    s_done = done_pulses; s_stab = stab_viol; s_gap = gap_viol; w0 = wlog.size();
    pulse_start(32'h1000, 32'h2000, 16'd4);
    check("a_first_req", 64'({m_mem_req, m_mem_we, busy}), 64'b101);
    check("a_first_addr", 64'(m_mem_addr), 64'h1000);
    wait_done("a", 200, cyc);
    check("a_latency", 64'(cyc), 64'(4*6 + 2));
    check("a_words", 64'(words_done), 64'd4);
    check("a_status", 64'({busy, aborted}), 64'd0);
    @(negedge clk);
    check("a_done_pulses", 64'(done_pulses - s_done), 64'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("a_dst%0d", i), 64'(mem[32'h2000 + 32'(4*i)]), 64'(32'hCAFE0000 + 32'(i)));
    check("a_dst_past_end", 64'(mem[32'h2010]), 64'h5A5A5A5A);
    check("a_writes", 64'(wlog.size() - w0), 64'd4);
    check("a_protocol", 64'({32'(stab_viol - s_stab), 32'(gap_viol - s_gap)}), 64'd0);

    // Zero-length job: no beats, done two cycles after start, busy for one cycle.
    s_req = req_cycles; s_busy = busy_cycles;
    pulse_start(32'h1000, 32'h3000, 16'd0);
    wait_done("z", 20, cyc);
    check("z_latency", 64'(cyc), 64'd2);
    @(negedge clk);
    check("z_no_req", 64'(req_cycles - s_req), 64'd0);
    check("z_busy_cycles", 64'(busy_cycles - s_busy), 64'd1);
    check("z_words", 64'(words_done), 64'd0);

    // 32-word copy with 0-3 random wait states and unaligned cfg addresses.
    rs = 32'h10000 + 32'($urandom_range(15, 0)) * 32'h100;
    rd = 32'h20000 + 32'($urandom_range(15, 0)) * 32'h100;
    for (int i = 0; i < 32; i++) begin
      vals[i] = $urandom;
      mem[rs + 32'(4*i)] = vals[i];
    end
    for (int i = 0; i <= 32; i++) mem[rd + 32'(4*i)] = 32'hDEAD0000 + 32'(i);
    min_wait = 0; max_wait = 3;
    s_stab = stab_viol; s_gap = gap_viol;
    pulse_start(rs | 32'($urandom_range(3, 0)), rd | 32'($urandom_range(3, 0)), 16'd32);
    wait_done("r", 1000, cyc);
    check("r_words", 64'(words_done), 64'd32);
    n = 0;
    for (int i = 0; i < 32; i++) if (mem[rd + 32'(4*i)] !== vals[i]) n++;
    check("r_dst_mismatches", 64'(n), 64'd0);
    check("r_dst_past_end", 64'(mem[rd + 32'd128]), 64'(32'hDEAD0000 + 32'd32));
    check("r_protocol", 64'({32'(stab_viol - s_stab), 32'(gap_viol - s_gap)}), 64'd0);

    // Abort during the read beat of word 2: read finishes, its write never issues.
    for (int i = 0; i < 5; i++) begin
      mem[32'h3000 + 32'(4*i)] = 32'hA0A00000 + 32'(i);
      mem[32'h4000 + 32'(4*i)] = 32'hEEEE0000 + 32'(i);
    end
    min_wait = 0; max_wait = 2;
    s_done = done_pulses; w0 = wlog.size();
    pulse_start(32'h3000, 32'h4000, 16'd5);
    check("b_aborted_cleared", 64'(aborted), 64'd0);
    guard = 0;
    while (!(m_mem_req === 1'b1 && m_mem_we === 1'b0 && m_mem_addr === 32'h3008) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("b_word2_read_seen", 64'(m_mem_addr), 64'h3008);
    abort = 1'b1;
    wait_done("b", 200, cyc);
    abort = 1'b0;
    check("b_aborted", 64'(aborted), 64'd1);
    check("b_words", 64'(words_done), 64'd2);
    n = 0;
    for (int i = w0; i < wlog.size(); i++) if (wlog[i] >= 32'h4008) n++;
    check("b_no_late_writes", 64'(n), 64'd0);
    check("b_dst1", 64'(mem[32'h4004]), 64'hA0A00001);
    check("b_dst2_untouched", 64'(mem[32'h4008]), 64'hEEEE0002);
    @(negedge clk);
    check("b_done_pulses", 64'(done_pulses - s_done), 64'd1);

    // Second start while busy must be ignored.
    for (int i = 0; i < 6; i++) begin
      mem[32'h5000 + 32'(4*i)] = $urandom;
      mem[32'h6000 + 32'(4*i)] = 32'h0;
    end
    mem[32'h8000] = 32'h11112222;
    min_wait = 0; max_wait = 3;
    s_done = done_pulses; w0 = wlog.size();
    pulse_start(32'h5000, 32'h6000, 16'd6);
    repeat (7) @(negedge clk);
    pulse_start(32'h7000, 32'h8000, 16'd2);
    wait_done("m", 300, cyc);
    check("m_words", 64'(words_done), 64'd6);
    n = 0;
    for (int i = 0; i < 6; i++) if (mem[32'h6000 + 32'(4*i)] !== mem[32'h5000 + 32'(4*i)]) n++;
    check("m_dst_mismatches", 64'(n), 64'd0);
    n = 0;
    for (int i = w0; i < wlog.size(); i++) if (wlog[i] < 32'h6000 || wlog[i] > 32'h6014) n++;
    check("m_stray_writes", 64'(n), 64'd0);
    check("m_other_dst", 64'(mem[32'h8000]), 64'h11112222);
    @(negedge clk);
    check("m_done_pulses", 64'(done_pulses - s_done), 64'd1);

    // Reset during the first write beat, then a fresh one-word job.
    for (int i = 0; i < 3; i++) begin
      mem[32'h9000 + 32'(4*i)] = 32'h90000000 + 32'(i);
      mem[32'hA000 + 32'(4*i)] = 32'hBBBB0000;
    end
    mem[32'h9100] = 32'h0BADBEEF;
    mem[32'hB000] = 32'h0;
    min_wait = 1; max_wait = 1;
    pulse_start(32'h9000, 32'hA000, 16'd3);
    guard = 0;
    while (!(m_mem_req === 1'b1 && m_mem_we === 1'b1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("x_wr_seen", 64'({m_mem_req, m_mem_we}), 64'b11);
    #1 rst = 1'b1;
    #1;
    check("x_req_async", 64'({m_mem_req, m_mem_we}), 64'd0);
    check("x_state_async", 64'({busy, done, aborted}), 64'd0);
    check("x_addr_async", {m_mem_addr, 16'(words_done), 16'h0}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("x_no_write", 64'(mem[32'hA000]), 64'hBBBB0000);
    pulse_start(32'h9100, 32'hB000, 16'd1);
    wait_done("x", 50, cyc);
    check("x_latency", 64'(cyc), 64'd8);
    check("x_words", 64'(words_done), 64'd1);
    check("x_dst", 64'(mem[32'hB000]), 64'h0BADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
